// File: rtl/alu_cmd_sequencer.sv
// Registered valid/ready front-end for the 6-bit combinational ALU.
// It holds the ALU operands in registers, keeps an accumulator and returns each result over a handshake.
module alu_cmd_sequencer #(
  parameter int WIDTH = 6,
  parameter int OPW   = 3,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_control,
  input  logic [WIDTH-1:0] alu_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic [WIDTH-1:0] acc,
  output logic [CNTW-1:0]  op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   res_hs;

  // A held result can be retired and replaced by a new command on the same edge.
  assign cmd_ready = (state == IDLE) || ((state == RESP) && res_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign res_valid = (state == RESP);
  assign res_hs    = (state == RESP) && res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      res_data    <= '0;
      res_zero    <= 1'b0;
      acc         <= '0;
      op_count    <= '0;
    end else begin
      if (accept) begin
        alu_control <= cmd_op;
        alu_b       <= cmd_b;
        // A clear forces operand A to zero, overriding the accumulator select.
        alu_a       <= acc_clr ? '0 : (cmd_use_acc ? acc : cmd_a);
        if (acc_clr) acc <= '0;
      end
      if (state == EXEC) begin
        res_data <= alu_c;
        acc      <= alu_c;
        res_zero <= (alu_c == '0);
      end
      if (res_hs) op_count <= op_count + 1'b1;
    end
  end

endmodule
